// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract unit.
// The master side supplies operands and consumes results; the slave side is
// the arithmetic unit itself.
interface serial_addsub_unit_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_overflow;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_carry
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// Digit-serial signed add/subtract unit.
// Operands are captured in IDLE, consumed DIGIT bits per cycle in RUN (LSB
// digit first) and the result is presented in DONE until the consumer takes it.
// Subtraction is A + ~B + 1: B is inverted on capture and the initial carry
// is set to 1.
module serial_addsub_unit #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_unit_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Refuse to elaborate when the digit does not tile the word exactly.
  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $fatal(1, "serial_addsub_unit: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] result_reg;
  logic             overflow_reg;
  logic             cout_reg;

  logic             accept;
  logic             ready;
  logic             valid;
  logic             last_step;
  logic [DIGIT:0]   digit_sum;
  logic             digit_overflow;
  logic [WIDTH-1:0] result_shifted;

  assign last_step = (count_reg == CW'(STEPS - 1));

  // One digit of the ripple: low digit of A and B plus the running carry.
  assign digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                   + (DIGIT + 1)'(carry_reg);

  // Carry into the digit MSB is a ^ b ^ sum at that bit; XOR with carry out
  // gives signed overflow when this is the top digit of the word.
  assign digit_overflow = a_reg[DIGIT-1] ^ b_reg[DIGIT-1]
                        ^ digit_sum[DIGIT-1] ^ digit_sum[DIGIT];

  // New digit enters at the MSB end so the LSB digit lands at bit 0 last.
  generate
    if (DIGIT == WIDTH) begin : g_full_digit
      assign result_shifted = digit_sum[DIGIT-1:0];
    end else begin : g_part_digit
      assign result_shifted = {digit_sum[DIGIT-1:0], result_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    valid      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit shifting and result/flag accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      count_reg    <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      cout_reg     <= 1'b0;
    end else if (accept) begin
      a_reg     <= bus.in_a;
      b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      carry_reg <= bus.in_sub;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg      <= a_reg >> DIGIT;
      b_reg      <= b_reg >> DIGIT;
      carry_reg  <= digit_sum[DIGIT];
      result_reg <= result_shifted;
      if (last_step) begin
        overflow_reg <= digit_overflow;
        cout_reg     <= digit_sum[DIGIT];
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = valid;
  assign bus.out_result   = result_reg;
  assign bus.out_overflow = overflow_reg;
  assign bus.out_carry    = cout_reg;

endmodule
